// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one single-precision multiplier core among
// NUM_REQ requesters, routes each result back to its issuer and times out a silent core.
module fp_mul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_op1,
    input  logic [32*NUM_REQ-1:0]  req_op2,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_res,
    output logic                   rsp_err,
    output logic                   mul_ready,
    output logic [31:0]            mul_op1,
    output logic [31:0]            mul_op2,
    input  logic [31:0]            mul_res,
    input  logic                   mul_done,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Handshakes: requester i holds req_valid[i] with stable operands until a
    // one-cycle req_ack[i]; the core sees a one-cycle mul_ready and answers with
    // mul_done; the result leaves as a one-cycle one-hot rsp_valid pulse.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_res_q, rsp_res_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 mul_ready_q, mul_ready_d;
    logic [31:0]          mul_op1_q, mul_op1_d;
    logic [31:0]          mul_op2_q, mul_op2_d;
    logic                 busy_q, busy_d;

    logic [PTR_W-1:0]     arb_idx;
    logic [31:0]          sel_op1, sel_op2;

    // First requesting port at or above rr_ptr, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [PTR_W-1:0]   ptr);
        logic             found;
        int               idx;
        logic [PTR_W-1:0] idx_b;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (int'(ptr) + i) % NUM_REQ;
            idx_b = idx[PTR_W-1:0];
            if (!found && v[idx_b]) begin
                found   = 1'b1;
                rr_pick = idx_b;
            end
        end
    endfunction

    always_comb begin
        arb_idx = rr_pick(req_valid, rr_ptr_q);
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == i[PTR_W-1:0]) begin
                sel_op1 = req_op1[32*i +: 32];
                sel_op2 = req_op2[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        wait_cnt_d  = wait_cnt_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_res_d   = rsp_res_q;
        rsp_err_d   = rsp_err_q;
        mul_ready_d = 1'b0;
        mul_op1_d   = mul_op1_q;
        mul_op2_d   = mul_op2_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d     = arb_idx;
                    mul_op1_d   = sel_op1;
                    mul_op2_d   = sel_op2;
                    mul_ready_d = 1'b1;
                    req_ack_d   = ONE << arb_idx;
                    wait_cnt_d  = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // mul_ready_q marks the first WAIT cycle, where a done level
                // may still be left over from the previous operation.
                if (mul_done && !mul_ready_q) begin
                    rsp_res_d = mul_res;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                    rsp_res_d = QNAN;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_d = ONE << grant_q;
                rr_ptr_d    = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            wait_cnt_q  <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
            mul_ready_q <= 1'b0;
            mul_op1_q   <= '0;
            mul_op2_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
            mul_ready_q <= mul_ready_d;
            mul_op1_q   <= mul_op1_d;
            mul_op2_q   <= mul_op2_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign mul_ready = mul_ready_q;
    assign mul_op1   = mul_op1_q;
    assign mul_op2   = mul_op2_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: a behavioural multiplier core, per-port requesters
// and a plan-based model of grant order, results and response latency.
module tb_fp_mul_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 64;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_op1, req_op2;
    logic [NUM_REQ-1:0]    req_ack, rsp_valid;
    logic [31:0]           rsp_res;
    logic                  rsp_err;
    logic                  mul_ready;
    logic [31:0]           mul_op1, mul_op2, mul_res;
    logic                  mul_done;
    logic                  busy;
    logic [1:0]            dbg_state;

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(mul_res),
        .mul_done(mul_done), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] f32_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [23:0] m;
        logic        g, s;
        int          e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; g = p[23]; s = |p[22:0]; e++;
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; s = |p[21:0];
        end
        if (g && (s || m[0])) m = m + 24'd1;
        if (m[23]) begin m = 24'd0; e++; end
        return {a[31] ^ b[31], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_f32();
        logic [31:0] r;
        r = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- core model: 0 normal, 1 holds done level, 2 never done ----------------
    int          core_lat  = 5;
    int          core_mode = 0;
    int          core_cnt  = 0;
    logic [31:0] core_a, core_b;

    initial begin
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mul_done = 1'b0;
                core_cnt = 0;
            end else if (mul_ready) begin
                core_a = mul_op1;
                core_b = mul_op2;
                if (core_mode != 1) mul_done = 1'b0;
                core_cnt = (core_mode == 2) ? 0 : core_lat;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    mul_done = 1'b1;
                    mul_res  = f32_mul(core_a, core_b);
                end else begin
                    mul_done = 1'b0;
                end
            end else if (core_mode != 1) begin
                mul_done = 1'b0;
            end
        end
    end

    // ---------------- requesters, plan and scoreboard queues ----------------
    logic [31:0] p_op1 [NUM_REQ][8];
    logic [31:0] p_op2 [NUM_REQ][8];
    int          p_n   [NUM_REQ];
    int          p_i   [NUM_REQ];
    int          rr_m = 0;

    int                 exp_port_q[$];
    logic [63:0]        exp_op_q[$];
    logic [32:0]        exp_q[$];
    int                 exp_lat_q[$];

    logic [NUM_REQ-1:0] obs_ack_q[$];
    logic [63:0]        obs_op_q[$];
    int                 obs_ack_cyc_q[$];
    logic [NUM_REQ-1:0] obs_rsp_q[$];
    logic [32:0]        obs_res_q[$];
    int                 obs_rsp_cyc_q[$];
    int                 ready_pulses;

    task automatic clear_plan();
        for (int i = 0; i < NUM_REQ; i++) begin
            p_n[i] = 0;
            p_i[i] = 0;
        end
        exp_port_q.delete(); exp_op_q.delete(); exp_q.delete(); exp_lat_q.delete();
    endtask

    // Served order: each decision picks the first still-pending port at or after
    // the port following the last one served.
    task automatic model_plan(input int lat, input logic err);
        int left[NUM_REQ];
        int used[NUM_REQ];
        int total, g;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = p_n[i];
            used[i] = 0;
            total += p_n[i];
        end
        while (total > 0) begin
            g = rr_m;
            while (left[g] == 0) g = (g + 1) % NUM_REQ;
            exp_port_q.push_back(g);
            exp_op_q.push_back({p_op1[g][used[g]], p_op2[g][used[g]]});
            exp_q.push_back(err ? {1'b1, QNAN} : {1'b0, f32_mul(p_op1[g][used[g]], p_op2[g][used[g]])});
            exp_lat_q.push_back(lat);
            left[g]--;
            used[g]++;
            total--;
            rr_m = (g + 1) % NUM_REQ;
        end
    endtask

    // ---------------- driver ----------------
    task automatic sample_cycle();
        @(negedge clk);
        if (mul_ready) ready_pulses++;
        if (req_ack != '0) begin
            obs_ack_q.push_back(req_ack);
            obs_op_q.push_back({mul_op1, mul_op2});
            obs_ack_cyc_q.push_back(cycle);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i]) begin
                    p_i[i]++;
                    if (p_i[i] < p_n[i]) begin
                        req_op1[32*i +: 32] = p_op1[i][p_i[i]];
                        req_op2[32*i +: 32] = p_op2[i][p_i[i]];
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (rsp_valid != '0) begin
            obs_rsp_q.push_back(rsp_valid);
            obs_res_q.push_back({rsp_err, rsp_res});
            obs_rsp_cyc_q.push_back(cycle);
        end
    endtask

    task automatic run_traffic(input int n_rsp, input int budget);
        obs_ack_q.delete(); obs_op_q.delete(); obs_ack_cyc_q.delete();
        obs_rsp_q.delete(); obs_res_q.delete(); obs_rsp_cyc_q.delete();
        ready_pulses = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            p_i[i] = 0;
            if (p_n[i] > 0) begin
                req_valid[i] = 1'b1;
                req_op1[32*i +: 32] = p_op1[i][0];
                req_op2[32*i +: 32] = p_op2[i][0];
            end
        end
        for (int c = 0; c < budget && obs_rsp_q.size() < n_rsp; c++) sample_cycle();
        if (obs_rsp_q.size() < n_rsp) begin
            checks++;
            errors++;
            $display("FAIL run_bound: got %0d responses, required %0d within %0d cycles",
                     obs_rsp_q.size(), n_rsp, budget);
        end
        repeat (4) sample_cycle();
        req_valid = '0;
    endtask

    task automatic fill_random(input int port, input int n);
        p_n[port] = n;
        for (int k = 0; k < n; k++) begin
            p_op1[port][k] = rand_f32();
            p_op2[port][k] = rand_f32();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_op1 = '0;
        req_op2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ack !== '0 || rsp_valid !== '0) begin
            errors++; $display("FAIL reset_pulses: ack=%b rsp=%b required 0", req_ack, rsp_valid);
        end
        checks++;
        if (rsp_res !== 32'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: res=%h err=%b required 0", rsp_res, rsp_err);
        end
        checks++;
        if (mul_ready !== 1'b0 || mul_op1 !== 32'd0 || mul_op2 !== 32'd0) begin
            errors++; $display("FAIL reset_core_if: ready=%b op1=%h op2=%h required 0", mul_ready, mul_op1, mul_op2);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        rst = 1'b0;
        rr_m = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ack !== '0 || mul_ready !== 1'b0) begin
            errors++; $display("FAIL idle_quiet: busy=%b ack=%b ready=%b required 0", busy, req_ack, mul_ready);
        end
    endtask

    task automatic test_single_op();
        core_mode = 0;
        core_lat  = 5;
        clear_plan();
        p_n[0] = 1;
        p_op1[0][0] = 32'h4000_0000;
        p_op2[0][0] = 32'h4040_0000;
        rr_m = 1;
        run_traffic(1, 40);
        checks++;
        if (obs_ack_q.size() != 1 || ready_pulses != 1) begin
            errors++; $display("FAIL single_pulses: acks=%0d readies=%0d required 1 and 1", obs_ack_q.size(), ready_pulses);
        end else begin
            checks++;
            if (obs_ack_q[0] !== 4'b0001) begin
                errors++; $display("FAIL single_ack: got %b required 0001", obs_ack_q[0]);
            end
        end
        checks++;
        if (obs_rsp_q.size() != 1) begin
            errors++; $display("FAIL single_rsp_count: got %0d required 1", obs_rsp_q.size());
        end else begin
            checks++;
            if (obs_rsp_q[0] !== 4'b0001 || obs_res_q[0] !== {1'b0, 32'h40C0_0000}) begin
                errors++; $display("FAIL single_rsp: valid=%b err_res=%h required 0001 and 0_40c00000", obs_rsp_q[0], obs_res_q[0]);
            end
            checks++;
            if (obs_ack_q.size() == 1 && obs_rsp_cyc_q[0] - obs_ack_cyc_q[0] != core_lat + 2) begin
                errors++; $display("FAIL single_latency: got %0d required %0d", obs_rsp_cyc_q[0] - obs_ack_cyc_q[0], core_lat + 2);
            end
        end
    endtask

    task automatic test_all_ports();
        logic [31:0] a[4] = '{32'h4000_0000, 32'h4080_0000, 32'h3FC0_0000, 32'hC0A0_0000};
        logic [31:0] b[4] = '{32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'h4000_0000};
        logic [31:0] r[4] = '{32'h40C0_0000, 32'h4000_0000, 32'h4010_0000, 32'hC120_0000};
        int n;
        test_reset();
        core_lat = 4;
        clear_plan();
        for (int i = 0; i < 4; i++) begin
            p_n[i] = 1;
            p_op1[i][0] = a[i];
            p_op2[i][0] = b[i];
        end
        run_traffic(4, 80);
        rr_m = 0;
        n = (obs_rsp_q.size() < obs_ack_q.size()) ? obs_rsp_q.size() : obs_ack_q.size();
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL all_count: got %0d required 4", n);
        end
        for (int k = 0; k < n && k < 4; k++) begin
            checks++;
            if (obs_ack_q[k] !== oh(k) || obs_rsp_q[k] !== oh(k)) begin
                errors++; $display("FAIL all_order[%0d]: ack=%b rsp=%b required %b", k, obs_ack_q[k], obs_rsp_q[k], oh(k));
            end
            checks++;
            if (obs_res_q[k] !== {1'b0, r[k]}) begin
                errors++; $display("FAIL all_result[%0d]: got %h required %h", k, obs_res_q[k], {1'b0, r[k]});
            end
        end
    endtask

    task automatic test_rr_wrap();
        int order[6] = '{1, 3, 1, 3, 1, 3};
        int n;
        core_lat = 3;
        clear_plan();
        fill_random(1, 3);
        fill_random(3, 3);
        model_plan(core_lat + 2, 1'b0);
        run_traffic(6, 100);
        n = obs_rsp_q.size();
        checks++;
        if (n != 6 || obs_ack_q.size() != 6) begin
            errors++; $display("FAIL rr_count: rsps=%0d acks=%0d required 6", n, obs_ack_q.size());
        end
        for (int k = 0; k < n && k < obs_ack_q.size() && k < 6; k++) begin
            checks++;
            if (obs_ack_q[k] !== oh(order[k]) || obs_rsp_q[k] !== oh(order[k])) begin
                errors++; $display("FAIL rr_order[%0d]: ack=%b rsp=%b required %b", k, obs_ack_q[k], obs_rsp_q[k], oh(order[k]));
            end
            checks++;
            if (obs_op_q[k] !== exp_op_q[k] || obs_res_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL rr_data[%0d]: ops=%h res=%h required %h %h", k, obs_op_q[k], obs_res_q[k], exp_op_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_stale_done();
        int n;
        core_mode = 1;
        core_lat  = 3;
        clear_plan();
        fill_random(0, 2);
        fill_random(1, 1);
        model_plan(core_lat + 2, 1'b0);
        run_traffic(3, 80);
        core_mode = 0;
        n = (obs_rsp_q.size() < obs_ack_q.size()) ? obs_rsp_q.size() : obs_ack_q.size();
        checks++;
        if (n != exp_port_q.size()) begin
            errors++; $display("FAIL stale_count: got %0d required %0d", n, exp_port_q.size());
        end
        for (int k = 0; k < n && k < exp_port_q.size(); k++) begin
            checks++;
            if (obs_rsp_q[k] !== oh(exp_port_q[k]) || obs_res_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL stale_result[%0d]: rsp=%b res=%h required %b %h", k, obs_rsp_q[k], obs_res_q[k], oh(exp_port_q[k]), exp_q[k]);
            end
            checks++;
            if (obs_rsp_cyc_q[k] - obs_ack_cyc_q[k] != exp_lat_q[k]) begin
                errors++; $display("FAIL stale_latency[%0d]: got %0d required %0d", k, obs_rsp_cyc_q[k] - obs_ack_cyc_q[k], exp_lat_q[k]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        core_mode = 2;
        clear_plan();
        fill_random(2, 1);
        model_plan(TIMEOUT_CYCLES, 1'b1);
        run_traffic(1, TIMEOUT_CYCLES + 20);
        checks++;
        if (obs_rsp_q.size() != 1 || obs_ack_q.size() != 1) begin
            errors++; $display("FAIL timeout_count: rsps=%0d acks=%0d required 1", obs_rsp_q.size(), obs_ack_q.size());
        end else begin
            checks++;
            if (obs_rsp_q[0] !== 4'b0100 || obs_res_q[0] !== {1'b1, QNAN}) begin
                errors++; $display("FAIL timeout_rsp: rsp=%b err_res=%h required 0100 1_7fc00000", obs_rsp_q[0], obs_res_q[0]);
            end
            checks++;
            if (obs_rsp_cyc_q[0] - obs_ack_cyc_q[0] != TIMEOUT_CYCLES) begin
                errors++; $display("FAIL timeout_latency: got %0d required %0d", obs_rsp_cyc_q[0] - obs_ack_cyc_q[0], TIMEOUT_CYCLES);
            end
        end
        core_mode = 0;
        core_lat  = 4;
        clear_plan();
        fill_random(0, 1);
        model_plan(core_lat + 2, 1'b0);
        run_traffic(1, 40);
        checks++;
        if (obs_rsp_q.size() != 1 || obs_rsp_q[0] !== 4'b0001 || obs_res_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL after_timeout: rsps=%0d res=%h required 1 response %h", obs_rsp_q.size(), obs_res_q.size() > 0 ? obs_res_q[0] : 33'h0, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic got;
        int   rsp_seen;
        core_mode = 0;
        core_lat  = 3;
        clear_plan();
        fill_random(2, 1);
        model_plan(core_lat + 2, 1'b0);
        run_traffic(1, 40);
        core_lat = 40;
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_op1[127:96] = rand_f32();
        req_op2[127:96] = rand_f32();
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_ack[3]) got = 1'b1;
        end
        req_valid = '0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL midwait_grant: ack[3] not seen, required within 10 cycles");
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mul_op1 !== 32'd0 || mul_op2 !== 32'd0 || rsp_res !== 32'd0) begin
            errors++; $display("FAIL async_reset: busy=%b op1=%h op2=%h res=%h required all 0", busy, mul_op1, mul_op2, rsp_res);
        end
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0) rsp_seen++;
        end
        rst = 1'b0;
        rr_m = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid != '0) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0) begin
            errors++; $display("FAIL dropped_op: rsp pulses=%0d required 0", rsp_seen);
        end
        core_lat = 3;
        clear_plan();
        fill_random(1, 1);
        fill_random(3, 1);
        model_plan(core_lat + 2, 1'b0);
        run_traffic(2, 40);
        checks++;
        if (obs_ack_q.size() != 2 || obs_ack_q[0] !== 4'b0010 || obs_ack_q[1] !== 4'b1000) begin
            errors++; $display("FAIL post_reset_order: acks=%0d first=%b required 0010 then 1000",
                               obs_ack_q.size(), obs_ack_q.size() > 0 ? obs_ack_q[0] : 4'b0);
        end
    endtask

    task automatic test_random();
        int n, total;
        for (int round = 0; round < 6; round++) begin
            core_mode = $urandom_range(0, 1);
            core_lat  = $urandom_range(1, 8);
            clear_plan();
            total = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 2) != 0 || (i == NUM_REQ - 1 && total == 0)) begin
                    fill_random(i, $urandom_range(1, 3));
                    total += p_n[i];
                end
            end
            model_plan(core_lat + 2, 1'b0);
            run_traffic(total, total * (core_lat + 4) + 20);
            n = (obs_rsp_q.size() < obs_ack_q.size()) ? obs_rsp_q.size() : obs_ack_q.size();
            checks++;
            if (obs_rsp_q.size() != total || obs_ack_q.size() != total) begin
                errors++; $display("FAIL rand%0d_count: rsps=%0d acks=%0d required %0d", round, obs_rsp_q.size(), obs_ack_q.size(), total);
            end
            for (int k = 0; k < n && k < total; k++) begin
                checks++;
                if (obs_ack_q[k] !== oh(exp_port_q[k]) || obs_rsp_q[k] !== oh(exp_port_q[k])) begin
                    errors++; $display("FAIL rand%0d_port[%0d]: ack=%b rsp=%b required %b", round, k, obs_ack_q[k], obs_rsp_q[k], oh(exp_port_q[k]));
                end
                checks++;
                if (obs_op_q[k] !== exp_op_q[k] || obs_res_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rand%0d_data[%0d]: ops=%h res=%h required %h %h", round, k, obs_op_q[k], obs_res_q[k], exp_op_q[k], exp_q[k]);
                end
                checks++;
                if (obs_rsp_cyc_q[k] - obs_ack_cyc_q[k] != exp_lat_q[k]) begin
                    errors++; $display("FAIL rand%0d_latency[%0d]: got %0d required %0d", round, k, obs_rsp_cyc_q[k] - obs_ack_cyc_q[k], exp_lat_q[k]);
                end
            end
            core_mode = 0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_op1 = '0;
        req_op2 = '0;
        test_reset();
        test_single_op();
        test_all_ports();
        test_rr_wrap();
        test_stale_done();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin arbiter that shares one IEEE754 single-precision multiplier core among NUM_REQ requesters. The core uses a ready/op1/op2 -> res/done handshake. The block sits between requester ports and the core. It serialises one operation at a time, returns each result to the requester that issued it, and guards the core with a done-timeout watchdog.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
TIMEOUT_CYCLES, 64, maximum WAIT cycles without mul_done before an error response (>= 4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  per-requester request; held high with operands stable until req_ack
req_op1  input  32*NUM_REQ  operand 1 of requester i, bits [32i+31:32i]
req_op2  input  32*NUM_REQ  operand 2 of requester i, bits [32i+31:32i]
req_ack  output  NUM_REQ  one-cycle one-hot pulse: operands of requester i captured
rsp_valid  output  NUM_REQ  one-cycle one-hot pulse: result for requester i on rsp_res
rsp_res  output  32  result bus, valid while rsp_valid != 0, holds its value otherwise
rsp_err  output  1  qualifies rsp_valid: 1 = timeout, rsp_res = 0x7FC00000
mul_ready  output  1  one-cycle start pulse to the core
mul_op1  output  32  operand 1 to the core, registered, stable from the mul_ready cycle until the next grant
mul_op2  output  32  operand 2 to the core, same rules as mul_op1
mul_res  input  32  core result
mul_done  input  1  core completion, sampled as described below
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset values: req_ack=0, rsp_valid=0, rsp_res=0, rsp_err=0, mul_ready=0, mul_op1=0, mul_op2=0, busy=0. Reset also sets state=IDLE, rr_ptr=0, wait counter=0.
- Reset is effective in any state. An operation in flight is dropped and no rsp_valid is issued for it. The core is reset by the same rst.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no req_valid: stay in IDLE, all pulses 0.
- IDLE, any req_valid set:
  - Grant g = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the clock edge: mul_op1/mul_op2 <= operands of g; mul_ready <= 1; req_ack[g] <= 1; busy <= 1; wait counter <= 0; state <= WAIT.
- WAIT:
  - mul_ready and req_ack return to 0 after one cycle.
  - mul_done is ignored in the first WAIT cycle (the cycle mul_ready is high). This masks a stale done level from the previous op. It is sampled from the second WAIT cycle on.
  - On sampled mul_done=1: rsp_res <= mul_res; rsp_err <= 0; state <= RESP.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT_CYCLES-1 without done: rsp_res <= 0x7FC00000; rsp_err <= 1; state <= RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid[g] = 1 for exactly this cycle.
  - At the edge: rr_ptr <= (g+1) mod NUM_REQ; state <= IDLE.
  - rsp_err clears at the next grant.
- Latency:
  - req_ack is high 1 cycle after req_valid is sampled in IDLE.
  - rsp_valid is high 2 cycles after the first cycle mul_done is sampled high.
  - Minimum spacing between consecutive grants is core latency + 3 cycles.
- Fairness:
  - A requester held continuously is granted within NUM_REQ grants.
  - The requester just served has lowest priority next.
- Ignored inputs: req_valid on ungranted ports is not acknowledged, and req_valid changes during WAIT/RESP are ignored. A requester that keeps req_valid high after its ack issues a new request.
- mul_op1/mul_op2 are unchanged outside IDLE grants.

Test Plan:
- Single op, port 0 = (0x40000000, 0x40400000), core latency 5 -> one req_ack[0] pulse; one mul_ready pulse; rsp_valid[0] with rsp_res=0x40C00000, rsp_err=0.
- All 4 ports request simultaneously after reset with distinct operands, e.g. port 2 = (0x3FC00000, 0x3FC00000) -> grant order 0,1,2,3; port 2 receives 0x40100000; each rsp_valid is one-hot and matches its own operands.
- Round-robin wrap: ports 1 and 3 hold req_valid high continuously for 6 grants -> grant order 1,3,1,3,1,3; no starvation.
- Stale done: core holds mul_done high from the previous op into the next mul_ready cycle -> the new op is not completed in its first WAIT cycle; the correct new result is returned.
- Timeout: core never asserts done, TIMEOUT_CYCLES=64 -> rsp_valid[g] 64 cycles after WAIT entry with rsp_err=1, rsp_res=0x7FC00000; the next grant proceeds normally.
- Reset mid-WAIT -> all outputs at their reset values asynchronously; no rsp_valid; after release, the first grant goes to the lowest-index active port (rr_ptr=0).
